// File: rtl/noobs_dmem_resp.sv
// Data-memory responder: the slave side of the CPU data port.
// It holds the data RAM and a 16-byte MMIO window with these registers:
//   +0 DBG_TX    debug FIFO push (reads 0)
//   +1 DBG_STAT  {4'b0, access_err, overflow, full, empty}; write bit2 clears overflow
//   +2 TMR_LO    timer low byte; a read also latches the high byte into the shadow
//   +3 TMR_HI    timer shadow
//   +4 SCRATCH   read/write byte
// The debug FIFO drains through the dbg_out valid/ready port.
// Optional build macro NOOBS_DMEM_TIMER_EN adds the free-running 16-bit timer.
// Without it, +2 and +3 read 0.
module noobs_dmem_resp #(
  parameter logic [11:0] MMIO_BASE  = 12'hFF0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] m_addr,
  input  logic [7:0]  m_wr_data,
  output logic [7:0]  m_rd_data,
  input  logic        m_en,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic [7:0]  dbg_out_data,
  output logic        dbg_out_vld,
  input  logic        dbg_out_rdy,
  output logic        access_err
);

  localparam int unsigned RamDepth = int'(MMIO_BASE);
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);

  localparam logic [3:0] RegDbgTx   = 4'd0;
  localparam logic [3:0] RegDbgStat = 4'd1;
  localparam logic [3:0] RegTmrLo   = 4'd2;
  localparam logic [3:0] RegTmrHi   = 4'd3;
  localparam logic [3:0] RegScratch = 4'd4;

  // Access decode
  logic        rd_req, wr_req, bad_req;
  logic        in_ram, in_mmio;
  logic [11:0] offset;
  logic [3:0]  reg_sel;

  assign rd_req  = m_en & m_rd & ~m_wr;
  assign wr_req  = m_en & m_wr & ~m_rd;
  assign bad_req = m_en & m_rd & m_wr;
  assign in_ram  = m_addr < MMIO_BASE;
  assign offset  = m_addr - MMIO_BASE;
  assign in_mmio = !in_ram && (offset < 12'd16);
  assign reg_sel = offset[3:0];

  // State
  logic [7:0]  ram_q [RamDepth];
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  scratch_q;
  logic        err_q, ovf_q;

  // FIFO status and handshake
  logic fifo_empty, fifo_full, pop, push_req, push_ok, ovf_set, ovf_clr, scratch_wr;

  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop        = !fifo_empty && dbg_out_rdy;
  assign push_req   = wr_req && in_mmio && (reg_sel == RegDbgTx);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign ovf_clr    = wr_req && in_mmio && (reg_sel == RegDbgStat) && m_wr_data[2];
  assign scratch_wr = wr_req && in_mmio && (reg_sel == RegScratch);

  // Timer view seen by the read mux
  logic [7:0] tmr_lo, tmr_hi;

`ifdef NOOBS_DMEM_TIMER_EN
  logic [15:0] timer_q;
  logic [7:0]  shadow_q;

  // Free-running timer; a TMR_LO read snapshots the high byte for a later TMR_HI read.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q  <= 16'h0000;
      shadow_q <= 8'h00;
    end else begin
      timer_q <= timer_q + 16'd1;
      if (rd_req && in_mmio && (reg_sel == RegTmrLo)) begin
        shadow_q <= timer_q[15:8];
      end
    end
  end

  assign tmr_lo = timer_q[7:0];
  assign tmr_hi = shadow_q;
`else
  assign tmr_lo = 8'h00;
  assign tmr_hi = 8'h00;
`endif

  // Read data selection for the registered read port
  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    if (in_ram) begin
      rd_val = ram_q[m_addr];
    end else if (in_mmio) begin
      case (reg_sel)
        RegDbgStat: rd_val = {4'b0000, err_q, ovf_q, fifo_full, fifo_empty};
        RegTmrLo:   rd_val = tmr_lo;
        RegTmrHi:   rd_val = tmr_hi;
        RegScratch: rd_val = scratch_q;
        default:    rd_val = 8'h00;
      endcase
    end
  end

  // RAM array; contents are not reset, and strobes are ignored while reset is high
  always_ff @(posedge clk) begin
    if (!reset && wr_req && in_ram) begin
      ram_q[m_addr] <= m_wr_data;
    end
  end

  // FIFO storage; pointers alone define occupancy, so no reset is needed
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo_q[wr_ptr_q[PtrW-1:0]] <= m_wr_data;
    end
  end

  // Control registers: read port, error/overflow flags, scratch, FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 8'h00;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      scratch_q <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (bad_req) begin
        rd_data_q <= 8'h00;
        err_q     <= 1'b1;
      end else if (rd_req) begin
        rd_data_q <= rd_val;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (scratch_wr) begin
        scratch_q <= m_wr_data;
      end
    end
  end

  assign m_rd_data    = rd_data_q;
  assign access_err   = err_q;
  assign dbg_out_vld  = !fifo_empty;
  // Gate the head byte so the output reads 0 while the FIFO is empty.
  assign dbg_out_data = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[PtrW-1:0]];

endmodule
